// File: rtl/action_sequencer.sv
// One-shot trigger sequencer: fires one pulse per enabled channel in ascending order, with optional repeat rounds.
// ACTION_SEQ_ROUND_CNT_EN adds a saturating 16-bit completed-round counter output.
module action_sequencer #(
  parameter  int CHANNELS = 8,
  parameter  int CNT_W    = 32,
  localparam int IDX_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      rpt,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [CHANNELS*CNT_W-1:0] delays,
  input  logic [CHANNELS*CNT_W-1:0] widths,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_W-1:0]          step_idx,
  output logic [CHANNELS-1:0]       out
`ifdef ACTION_SEQ_ROUND_CNT_EN
  ,
  output logic [15:0]               rounds
`endif
);

  typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CHANNELS-1:0]       out_q, out_d;
  logic [CHANNELS-1:0]       en_q, en_d;
  logic [CHANNELS*CNT_W-1:0] dly_q, dly_d;
  logic [CHANNELS*CNT_W-1:0] wid_q, wid_d;
  logic                      rpt_q, rpt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [CHANNELS*CNT_W-1:0] src_dly, src_wid;
  logic [CHANNELS-1:0]       above;
  logic [CNT_W-1:0]          cur_wid, ent_dly, ent_wid;
  logic [IDX_W-1:0]          enter_idx;
  logic                      enter;
  logic                      round_end;
  logic                      round_clr;

  function automatic logic [IDX_W-1:0] lowest(input logic [CHANNELS-1:0] m);
    lowest = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (m[i]) lowest = IDX_W'(i);
    end
  endfunction

  function automatic logic [CNT_W-1:0] width_cnt(input logic [CNT_W-1:0] w);
    width_cnt = (w == '0) ? '0 : w - CNT_W'(1);
  endfunction

  // While idle the first channel is loaded straight from the inputs being latched.
  assign src_dly = (state_q == IDLE) ? delays : dly_q;
  assign src_wid = (state_q == IDLE) ? widths : wid_q;
  assign cur_wid = wid_q[int'(idx_q)*CNT_W +: CNT_W];

  always_comb begin
    above = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      above[i] = en_q[i] && (i > int'(idx_q));
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    out_d     = out_q;
    en_d      = en_q;
    dly_d     = dly_q;
    wid_d     = wid_q;
    rpt_d     = rpt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    enter     = 1'b0;
    enter_idx = '0;
    ent_dly   = '0;
    ent_wid   = '0;
    round_end = 1'b0;
    round_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          en_d      = ch_en;
          dly_d     = delays;
          wid_d     = widths;
          rpt_d     = rpt;
          round_clr = 1'b1;
          if (|ch_en) begin
            enter     = 1'b1;
            enter_idx = lowest(ch_en);
            busy_d    = 1'b1;
          end else begin
            done_d    = 1'b1;
            round_end = 1'b1;
          end
        end
      end
      DELAY: begin
        if (abort) begin
          state_d = IDLE;
          out_d   = '0;
          busy_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = PULSE;
          out_d   = CHANNELS'(1) << idx_q;
          cnt_d   = width_cnt(cur_wid);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (abort) begin
          state_d = IDLE;
          out_d   = '0;
          busy_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          out_d = '0;
          if (|above) begin
            enter     = 1'b1;
            enter_idx = lowest(above);
          end else begin
            done_d    = 1'b1;
            round_end = 1'b1;
            if (rpt_q) begin
              enter     = 1'b1;
              enter_idx = lowest(en_q);
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              idx_d   = '0;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A zero pre-delay skips DELAY so the pulse lands in the very next cycle.
    if (enter) begin
      ent_dly = src_dly[int'(enter_idx)*CNT_W +: CNT_W];
      ent_wid = src_wid[int'(enter_idx)*CNT_W +: CNT_W];
      idx_d   = enter_idx;
      if (ent_dly == '0) begin
        state_d = PULSE;
        out_d   = CHANNELS'(1) << enter_idx;
        cnt_d   = width_cnt(ent_wid);
      end else begin
        state_d = DELAY;
        out_d   = '0;
        cnt_d   = ent_dly - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      en_q    <= '0;
      dly_q   <= '0;
      wid_q   <= '0;
      rpt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      en_q    <= en_d;
      dly_q   <= dly_d;
      wid_q   <= wid_d;
      rpt_q   <= rpt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;
  assign out      = out_q;

`ifdef ACTION_SEQ_ROUND_CNT_EN
  logic [15:0] rounds_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rounds_q <= '0;
    end else if (round_clr) begin
      rounds_q <= round_end ? 16'd1 : 16'd0;
    end else if (round_end && rounds_q != 16'hFFFF) begin
      rounds_q <= rounds_q + 16'd1;
    end
  end

  assign rounds = rounds_q;
`else
  logic unused_round;
  assign unused_round = round_end ^ round_clr;
`endif

endmodule
